shift_seq: RTL

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq_if.sv | 18 +
 rtl/shift_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/shift_seq_if.sv
// Handshake and data bundle between a shift_seq client and the sequencer.
interface shift_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic             kick;
    logic             flush;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [SW-1:0]    b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] q;

    modport master (output kick, flush, op, a, b, input ready, done, q);
    modport slave  (input kick, flush, op, a, b, output ready, done, q);
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shifter/rotator: shifts by up to STEP positions per clock
// until the requested amount is consumed, then pulses done for one cycle.
//
// state | meaning
// IDLE  | ready for kick; q holds the last result
// RUN   | consuming cnt_q, STEP positions (or fewer) per edge
module shift_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    shift_seq_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    // One extra bit so STEP == WIDTH is representable in the compare.
    localparam logic [SW:0] STEP_C = (SW+1)'(STEP);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [SW-1:0]    k_s;
    logic [SW-1:0]    rem_s;

    // Shift/rotate v by amt (< WIDTH); unknown op codes pass v through.
    function automatic logic [WIDTH-1:0] shift_f(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] v,
                                                 input logic [SW-1:0] amt);
        logic [SW:0]      inv;
        logic [WIDTH-1:0] r;
        inv = (SW+1)'(WIDTH) - {1'b0, amt};
        case (op)
            3'b000:  r = v << amt;
            3'b001:  r = v >> amt;
            3'b010:  r = $signed(v) >>> amt;
            // amt == 0 gives a shift by WIDTH on the wrap half, which is 0.
            3'b011:  r = (v << amt) | (v >> inv);
            3'b100:  r = (v >> amt) | (v << inv);
            default: r = v;
        endcase
        return r;
    endfunction

    // Per-edge step size: whatever is left, capped at STEP.
    assign k_s   = ({1'b0, cnt_q} < STEP_C) ? cnt_q : STEP_C[SW-1:0];
    assign rem_s = cnt_q - k_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush only matters in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.kick && (bus.b != '0)) state_d = RUN;
            RUN:  if (bus.flush || (rem_s == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: accept loads operands, RUN shifts, flush freezes q.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.kick) begin
                q_d    = bus.a;
                cnt_d  = bus.b;
                op_d   = bus.op;
                done_d = (bus.b == '0);
            end
        end else if (bus.flush) begin
            cnt_d = '0;
        end else begin
            q_d    = shift_f(op_q, q_q, k_s);
            cnt_d  = rem_s;
            done_d = (rem_s == '0);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            cnt_q  <= '0;
            op_q   <= 3'b000;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            done_q <= done_d;
        end
    end

    // Outputs: ready is decoded straight from the state.
    always_comb begin
        bus.ready = (state_q == IDLE);
        bus.done  = done_q;
        bus.q     = q_q;
    end
endmodule
